// File: rtl/traffic_conflict_monitor.sv
// Receive-side safety checker for the {N,E,S,W} light bus; latches a fault and forces outputs safe.
// Optional MON_FLASH_EN: in FAULT the outputs flash all-red/all-yellow on each tick.
module traffic_conflict_monitor #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_YELLOW = 1,
    parameter int WDOG_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lights_in,
    input  logic       clr,
    output logic [7:0] lights_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [3:0] fault_dir,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
    localparam int WW = (WDOG_TICKS > 0) ? $clog2(WDOG_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_YELLOW);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_TICKS);

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] ILL = 2'b11;

    localparam logic [7:0] ALL_RED = 8'h00;
    localparam logic [7:0] ALL_YEL = 8'h55;

    localparam logic [2:0] C_NONE    = 3'd0;
    localparam logic [2:0] C_INVALID = 3'd1;
    localparam logic [2:0] C_CONFLICT = 3'd2;
    localparam logic [2:0] C_BADTRANS = 3'd3;
    localparam logic [2:0] C_SHORTY  = 3'd4;
    localparam logic [2:0] C_STUCK   = 3'd5;

    typedef enum logic [1:0] {
        S_ARM,
        S_RUN,
        S_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        pre_q;
    logic [7:0]           prev_q, prev_d;
    logic [3:0][DW-1:0]   dwell_q, dwell_d;
    logic [WW-1:0]        wdog_q, wdog_d;
    logic [7:0]           lights_q, lights_d;
    logic                 fault_q, fault_d;
    logic [2:0]           code_q, code_d;
    logic [3:0]           dir_q, dir_d;

    logic [3:0] inv, grn, chg, bad, shorty;
    logic       conflict, stuck;
    logic       hard_viol, run_viol;
    logic [2:0] hard_code, run_code;
    logic [3:0] hard_dir, run_dir;

    assign tick       = (pre_q == PRE_LAST);
    assign lights_out = lights_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_dir  = dir_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Per-direction classification; bit i covers lights[2i+1:2i] (bit 3 = N).
    always_comb begin
        inv    = '0;
        grn    = '0;
        chg    = '0;
        bad    = '0;
        shorty = '0;
        for (int i = 0; i < 4; i++) begin
            inv[i] = (lights_in[2*i +: 2] == ILL);
            grn[i] = (lights_in[2*i +: 2] == GRN);
            chg[i] = (lights_in[2*i +: 2] != prev_q[2*i +: 2]);
            bad[i] = ((prev_q[2*i +: 2] == RED) && (lights_in[2*i +: 2] == GRN))
                  || ((prev_q[2*i +: 2] == GRN) && (lights_in[2*i +: 2] == RED));
            shorty[i] = (prev_q[2*i +: 2] == YEL)
                     && (lights_in[2*i +: 2] == RED)
                     && (dwell_q[i] < DWELL_MAX);
        end
        conflict = ((grn & (grn - 4'd1)) != 4'd0);
        stuck    = (wdog_q == WDOG_MAX);
    end

    // Pattern-level faults are valid in every state; transition faults only in RUN.
    always_comb begin
        hard_viol = 1'b0;
        hard_code = C_NONE;
        hard_dir  = '0;
        if (|inv) begin
            hard_viol = 1'b1;
            hard_code = C_INVALID;
            hard_dir  = inv;
        end else if (conflict) begin
            hard_viol = 1'b1;
            hard_code = C_CONFLICT;
            hard_dir  = grn;
        end

        run_viol = hard_viol;
        run_code = hard_code;
        run_dir  = hard_dir;
        if (!hard_viol) begin
            if (|bad) begin
                run_viol = 1'b1;
                run_code = C_BADTRANS;
                run_dir  = bad;
            end else if (|shorty) begin
                run_viol = 1'b1;
                run_code = C_SHORTY;
                run_dir  = shorty;
            end else if (stuck) begin
                run_viol = 1'b1;
                run_code = C_STUCK;
                run_dir  = 4'b1111;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        dwell_d  = dwell_q;
        wdog_d   = wdog_q;
        lights_d = lights_q;
        fault_d  = fault_q;
        code_d   = code_q;
        dir_d    = dir_q;
        unique case (state_q)
            S_ARM: begin
                prev_d  = lights_in;
                dwell_d = '0;
                wdog_d  = '0;
                if (hard_viol) begin
                    state_d  = S_FAULT;
                    fault_d  = 1'b1;
                    code_d   = hard_code;
                    dir_d    = hard_dir;
                    lights_d = ALL_RED;
                end else begin
                    state_d  = S_RUN;
                    lights_d = lights_in;
                end
            end
            S_RUN: begin
                if (run_viol) begin
                    state_d  = S_FAULT;
                    fault_d  = 1'b1;
                    code_d   = run_code;
                    dir_d    = run_dir;
                    lights_d = ALL_RED;
                end else begin
                    lights_d = lights_in;
                    prev_d   = lights_in;
                    // A change on a tick cycle clears rather than counts.
                    for (int i = 0; i < 4; i++) begin
                        if (chg[i]) begin
                            dwell_d[i] = '0;
                        end else if (tick && (dwell_q[i] != DWELL_MAX)) begin
                            dwell_d[i] = dwell_q[i] + 1'b1;
                        end
                    end
                    if (|chg) begin
                        wdog_d = '0;
                    end else if (tick && (wdog_q != WDOG_MAX)) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                if (clr && !hard_viol) begin
                    state_d  = S_ARM;
                    fault_d  = 1'b0;
                    code_d   = C_NONE;
                    dir_d    = '0;
                    lights_d = ALL_RED;
                end else begin
`ifdef MON_FLASH_EN
                    if (tick) begin
                        lights_d = (lights_q == ALL_RED) ? ALL_YEL : ALL_RED;
                    end
`else
                    lights_d = ALL_RED;
`endif
                end
            end
            default: begin
                state_d = S_ARM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_ARM;
            prev_q   <= '0;
            dwell_q  <= '0;
            wdog_q   <= '0;
            lights_q <= '0;
            fault_q  <= 1'b0;
            code_q   <= C_NONE;
            dir_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            dwell_q  <= dwell_d;
            wdog_q   <= wdog_d;
            lights_q <= lights_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            dir_q    <= dir_d;
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor (TICK_DIV=4, MIN_YELLOW=1, WDOG_TICKS=8).
module tb_traffic_conflict_monitor;

    localparam int TD = 4;
    localparam int MY = 1;
    localparam int WD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] lights_in = 8'h00;
    logic [7:0] lights_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [3:0] fault_dir;
    logic       tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       f;
        logic [2:0] code;
        logic [3:0] dir;
        logic [7:0] lo;
    } exp_t;

    exp_t q[$];

    logic [7:0] pats [9] = '{8'h80, 8'h50, 8'h20, 8'h14, 8'h08,
                             8'h05, 8'h02, 8'h41, 8'h80};

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .TICK_DIV(TD),
        .MIN_YELLOW(MY),
        .WDOG_TICKS(WD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lights_in(lights_in),
        .clr(clr),
        .lights_out(lights_out),
        .fault(fault),
        .fault_code(fault_code),
        .fault_dir(fault_dir),
        .tick(tick)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just past its ARM edge, i.e. in RUN with prev = init.
    task automatic apply_reset(input logic [7:0] init);
        reset = 1'b0;
        clr = 1'b0;
        lights_in = init;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic wait_fault(input int budget, output int lat);
        lat = 0;
        while (fault !== 1'b1 && lat < budget) begin
            cyc();
            lat++;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (lights_out !== 8'h00 || fault !== 1'b0 || fault_code !== 3'd0
            || fault_dir !== 4'd0) begin
            errors++;
            $display("FAIL reset_vals: got out=%h f=%0b code=%0d dir=%b, want 00 0 0 0000",
                     lights_out, fault, fault_code, fault_dir);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %0b want 0", tick);
        end
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_edge2: got %0b want 0", tick);
        end
        cyc();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_edge3: got %0b want 1", tick);
        end
        cyc();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_edge4: got %0b want 0", tick);
        end
        cyc();
        cyc();
        cyc();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_edge7: got %0b want 1", tick);
        end
    endtask

    task automatic test_legal_cycle();
        exp_t e;
        apply_reset(8'h80);
        foreach (pats[k]) begin
            for (int j = 0; j < 2 * TD; j++) begin
                lights_in = pats[k];
                q.push_back('{f: 1'b0, code: 3'd0, dir: 4'd0, lo: pats[k]});
                cyc();
                e = q.pop_front();
                checks++;
                if (fault !== e.f || fault_code !== e.code || fault_dir !== e.dir
                    || lights_out !== e.lo) begin
                    errors++;
                    $display("FAIL legal_pass: got f=%0b code=%0d dir=%b out=%h, want f=%0b code=%0d dir=%b out=%h",
                             fault, fault_code, fault_dir, lights_out, e.f, e.code, e.dir, e.lo);
                end
            end
        end
    endtask

    task automatic test_conflict_and_clear();
        exp_t e;
        int lat;
        apply_reset(8'h00);
        lights_in = 8'hA0;
        q.push_back('{f: 1'b1, code: 3'd2, dir: 4'b1100, lo: 8'h00});
        wait_fault(8, lat);
        e = q.pop_front();
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL conflict_latency: got %0d want 1", lat);
        end
        checks++;
        if (fault !== e.f || fault_code !== e.code || fault_dir !== e.dir
            || lights_out !== e.lo) begin
            errors++;
            $display("FAIL conflict: got f=%0b code=%0d dir=%b out=%h, want f=%0b code=%0d dir=%b out=%h",
                     fault, fault_code, fault_dir, lights_out, e.f, e.code, e.dir, e.lo);
        end
        lights_in = 8'hA3;
        cyc();
        cyc();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || fault_dir !== 4'b1100) begin
            errors++;
            $display("FAIL first_fault_wins: got f=%0b code=%0d dir=%b, want 1 2 1100",
                     fault, fault_code, fault_dir);
        end
        clr = 1'b1;
        lights_in = 8'hA0;
        cyc();
        cyc();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd2) begin
            errors++;
            $display("FAIL clr_blocked: got f=%0b code=%0d, want 1 2", fault, fault_code);
        end
        lights_in = 8'h00;
        cyc();
        clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || fault_dir !== 4'd0) begin
            errors++;
            $display("FAIL clr_accept: got f=%0b code=%0d dir=%b, want 0 0 0000",
                     fault, fault_code, fault_dir);
        end
        for (int j = 0; j < 4; j++) begin
            lights_in = 8'h20;
            q.push_back('{f: 1'b0, code: 3'd0, dir: 4'd0, lo: 8'h20});
            cyc();
            e = q.pop_front();
            checks++;
            if (fault !== e.f || lights_out !== e.lo) begin
                errors++;
                $display("FAIL resume_pass: got f=%0b out=%h, want f=%0b out=%h",
                         fault, lights_out, e.f, e.lo);
            end
        end
    endtask

    task automatic test_invalid_priority();
        exp_t e;
        int lat;
        apply_reset(8'h00);
        lights_in = 8'hAB;
        q.push_back('{f: 1'b1, code: 3'd1, dir: 4'b0001, lo: 8'h00});
        wait_fault(8, lat);
        e = q.pop_front();
        checks++;
        if (fault !== e.f || fault_code !== e.code || fault_dir !== e.dir
            || lights_out !== e.lo) begin
            errors++;
            $display("FAIL invalid_prio: got f=%0b code=%0d dir=%b out=%h, want f=%0b code=%0d dir=%b out=%h",
                     fault, fault_code, fault_dir, lights_out, e.f, e.code, e.dir, e.lo);
        end
    endtask

    task automatic test_bad_trans();
        exp_t e;
        int lat;
        apply_reset(8'h80);
        lights_in = 8'h00;
        q.push_back('{f: 1'b1, code: 3'd3, dir: 4'b1000, lo: 8'h00});
        wait_fault(8, lat);
        e = q.pop_front();
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL bad_trans_latency: got %0d want 1", lat);
        end
        checks++;
        if (fault !== e.f || fault_code !== e.code || fault_dir !== e.dir
            || lights_out !== e.lo) begin
            errors++;
            $display("FAIL bad_trans: got f=%0b code=%0d dir=%b out=%h, want f=%0b code=%0d dir=%b out=%h",
                     fault, fault_code, fault_dir, lights_out, e.f, e.code, e.dir, e.lo);
        end
    endtask

    task automatic test_short_yellow();
        exp_t e;
        int lat;
        int n;
        apply_reset(8'h00);
        n = 0;
        while (tick !== 1'b1 && n < 2 * TD) begin
            cyc();
            n++;
        end
        lights_in = 8'h40;
        cyc();
        lights_in = 8'h00;
        q.push_back('{f: 1'b1, code: 3'd4, dir: 4'b1000, lo: 8'h00});
        wait_fault(8, lat);
        e = q.pop_front();
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL short_yellow_latency: got %0d want 1", lat);
        end
        checks++;
        if (fault !== e.f || fault_code !== e.code || fault_dir !== e.dir
            || lights_out !== e.lo) begin
            errors++;
            $display("FAIL short_yellow: got f=%0b code=%0d dir=%b out=%h, want f=%0b code=%0d dir=%b out=%h",
                     fault, fault_code, fault_dir, lights_out, e.f, e.code, e.dir, e.lo);
        end
        // Yellow held across exactly one tick is long enough.
        apply_reset(8'h00);
        n = 0;
        while (tick !== 1'b1 && n < 2 * TD) begin
            cyc();
            n++;
        end
        lights_in = 8'h40;
        cyc();
        n = 0;
        while (tick !== 1'b1 && n < 2 * TD) begin
            cyc();
            n++;
        end
        cyc();
        lights_in = 8'h00;
        cyc();
        cyc();
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || lights_out !== 8'h00) begin
            errors++;
            $display("FAIL yellow_min_ok: got f=%0b code=%0d out=%h, want 0 0 00",
                     fault, fault_code, lights_out);
        end
    endtask

    task automatic test_stuck();
        exp_t e;
        int n;
        int nt;
        logic t;
        apply_reset(8'h00);
        q.push_back('{f: 1'b1, code: 3'd5, dir: 4'b1111, lo: 8'h00});
        n = 0;
        nt = 0;
        while (fault !== 1'b1 && n < (WD + 3) * TD) begin
            t = tick;
            cyc();
            n++;
            if (t) nt++;
        end
        e = q.pop_front();
        checks++;
        if (fault !== e.f || fault_code !== e.code || fault_dir !== e.dir
            || lights_out !== e.lo) begin
            errors++;
            $display("FAIL stuck: got f=%0b code=%0d dir=%b out=%h, want f=%0b code=%0d dir=%b out=%h",
                     fault, fault_code, fault_dir, lights_out, e.f, e.code, e.dir, e.lo);
        end
        checks++;
        if (nt !== WD) begin
            errors++;
            $display("FAIL stuck_ticks: got %0d ticks want %0d", nt, WD);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || fault_dir !== 4'd0
            || lights_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_fault: got f=%0b code=%0d dir=%b out=%h, want 0 0 0000 00",
                     fault, fault_code, fault_dir, lights_out);
        end
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_conflict_and_clear();
        test_invalid_priority();
        test_bad_trans();
        test_short_yellow();
        test_stuck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
